rv32v_lane_sequencer: RTL and testbench

RV32V_LANE_SEQUENCER -- requirements
Module: rv32v_lane_sequencer

---
 rtl/rv32v_types_pkg.sv | 15 +
 rtl/rv32v_seq_mask_sel.sv | 39 +++
 rtl/rv32v_lane_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rv32v_lane_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared types for the RV32V lane sequencer: element offsets and sequencer FSM states.
package rv32v_types_pkg;

   typedef logic [31:0] offset_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   // Two lanes retire two consecutive elements per RUN cycle.
   localparam offset_t OFFSET_STEP = 32'd2;

endpackage

// File: rtl/rv32v_seq_mask_sel.sv
// Per-lane mask-bit selection from v0 for the two element offsets being issued.
// Only instantiated when RV32V_SEQ_MASK_EN is defined.
module rv32v_seq_mask_sel
   import rv32v_types_pkg::*;
#(
   parameter int unsigned VLMAX = 128
) (
   input  logic             vm,
   input  logic [VLMAX-1:0] mask,
   input  offset_t          off0,
   input  offset_t          off1,
   output logic [1:0]       lane_en
);

   localparam int unsigned IW = (VLMAX > 1) ? $clog2(VLMAX) : 1;

   // Offsets outside the mask register read as inactive.
   function automatic logic mask_bit(input logic [VLMAX-1:0] m, input offset_t off);
      logic b;
      b = 1'b0;
      if (off < offset_t'(VLMAX)) begin
         b = m[off[IW-1:0]];
      end else begin
         b = 1'b0;
      end
      return b;
   endfunction

   // Unmasked operation (vm=1) enables both lanes.
   always_comb begin
      lane_en = 2'b11;
      if (vm) begin
         lane_en = 2'b11;
      end else begin
         lane_en = {mask_bit(mask, off1), mask_bit(mask, off0)};
      end
   end

endmodule

// File: rtl/rv32v_lane_sequencer.sv
// Two-lane vector element sequencer (IDLE -> RUN -> DONE), all outputs registered.
// Optional element masking is enabled by defining RV32V_SEQ_MASK_EN.
module rv32v_lane_sequencer
   import rv32v_types_pkg::*;
#(
   parameter int unsigned VLMAX = 128
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   output logic             ready,
   input  logic [31:0]      vl,
   input  logic [31:0]      vstart,
   input  logic             stall,
   input  logic             flush,
`ifdef RV32V_SEQ_MASK_EN
   input  logic             vm,
   input  logic [VLMAX-1:0] mask_v0,
`endif
   output offset_t          woffset0,
   output offset_t          woffset1,
   output logic [1:0]       wen,
   output logic             busy,
   output logic             done
);

   localparam offset_t VLMAX_OFF = offset_t'(VLMAX);

   seq_state_t state_r;
   offset_t    idx_r;
   offset_t    vle_r;

   logic       accept_s;
   offset_t    vl_clamp_s;
   offset_t    base_s;
   offset_t    base_p1_s;
   offset_t    limit_s;
   logic       issue_s;
   logic [1:0] bound_wen_s;
   logic [1:0] next_wen_s;

   // Next element pair: vstart on accept, otherwise two past the current pair.
   always_comb begin
      accept_s   = (state_r == ST_IDLE) && start;
      vl_clamp_s = (vl > VLMAX_OFF) ? VLMAX_OFF : vl;
      if (accept_s) begin
         base_s  = vstart;
         limit_s = vl_clamp_s;
      end else begin
         base_s  = idx_r + OFFSET_STEP;
         limit_s = vle_r;
      end
      base_p1_s   = base_s + 32'd1;
      issue_s     = base_s < limit_s;
      bound_wen_s = {issue_s && (base_p1_s < limit_s), issue_s};
   end

`ifdef RV32V_SEQ_MASK_EN
   logic             vm_r;
   logic [VLMAX-1:0] mask_r;
   logic             vm_src_s;
   logic [VLMAX-1:0] mask_src_s;
   logic [1:0]       lane_en_s;

   // Mask operands come straight from the ports in the accept cycle.
   always_comb begin
      if (accept_s) begin
         vm_src_s   = vm;
         mask_src_s = mask_v0;
      end else begin
         vm_src_s   = vm_r;
         mask_src_s = mask_r;
      end
   end

   rv32v_seq_mask_sel #(
      .VLMAX   (VLMAX)
   ) u_mask_sel (
      .vm      (vm_src_s),
      .mask    (mask_src_s),
      .off0    (base_s),
      .off1    (base_p1_s),
      .lane_en (lane_en_s)
   );

   assign next_wen_s = bound_wen_s & lane_en_s;

   // Mask operands are captured once per instruction.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vm_r   <= 1'b1;
         mask_r <= '0;
      end else if (accept_s && !flush) begin
         vm_r   <= vm;
         mask_r <= mask_v0;
      end else begin
         vm_r   <= vm_r;
         mask_r <= mask_r;
      end
   end
`else
   assign next_wen_s = bound_wen_s;
`endif

   // Sequencer FSM with registered outputs; RST beats flush beats start/stall.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= ST_IDLE;
         idx_r    <= 32'd0;
         vle_r    <= 32'd0;
         woffset0 <= 32'd0;
         woffset1 <= 32'd0;
         wen      <= 2'b00;
         busy     <= 1'b0;
         done     <= 1'b0;
         ready    <= 1'b1;
      end else if (flush) begin
         state_r <= ST_IDLE;
         wen     <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
         ready   <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  vle_r <= vl_clamp_s;
                  idx_r <= vstart;
                  busy  <= 1'b1;
                  ready <= 1'b0;
                  if (issue_s) begin
                     state_r  <= ST_RUN;
                     woffset0 <= base_s;
                     woffset1 <= base_p1_s;
                     wen      <= next_wen_s;
                     done     <= 1'b0;
                  end else begin
                     state_r <= ST_DONE;
                     wen     <= 2'b00;
                     done    <= 1'b1;
                  end
               end else begin
                  done <= 1'b0;
               end
            end
            ST_RUN: begin
               if (stall) begin
                  state_r <= ST_RUN;
               end else if (issue_s) begin
                  idx_r    <= base_s;
                  woffset0 <= base_s;
                  woffset1 <= base_p1_s;
                  wen      <= next_wen_s;
               end else begin
                  state_r <= ST_DONE;
                  wen     <= 2'b00;
                  done    <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               wen     <= 2'b00;
               done    <= 1'b0;
               busy    <= 1'b0;
               ready   <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
               wen     <= 2'b00;
               done    <= 1'b0;
               busy    <= 1'b0;
               ready   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32v_lane_sequencer.sv
// Directed bench for rv32v_lane_sequencer with a cycle-level reference model and literal spot checks.
// Exercises masking as well when RV32V_SEQ_MASK_EN is defined.
module tb_rv32v_lane_sequencer;
   import rv32v_types_pkg::*;

   localparam int unsigned VLMAX = 128;

   logic        CLK = 1'b0;
   logic        RST;
   logic        start;
   logic        ready;
   logic [31:0] vl;
   logic [31:0] vstart;
   logic        stall;
   logic        flush;
   offset_t     woffset0;
   offset_t     woffset1;
   logic [1:0]  wen;
   logic        busy;
   logic        done;
`ifdef RV32V_SEQ_MASK_EN
   logic             vm;
   logic [VLMAX-1:0] mask_v0;
`endif

   int vectors     = 0;
   int miscompares = 0;
   bit check_en    = 1'b0;

   rv32v_lane_sequencer #(.VLMAX(VLMAX)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .start    (start),
      .ready    (ready),
      .vl       (vl),
      .vstart   (vstart),
      .stall    (stall),
      .flush    (flush),
`ifdef RV32V_SEQ_MASK_EN
      .vm       (vm),
      .mask_v0  (mask_v0),
`endif
      .woffset0 (woffset0),
      .woffset1 (woffset1),
      .wen      (wen),
      .busy     (busy),
      .done     (done)
   );

   always #5 CLK = ~CLK;

   // Reference model: what the outputs must be after each rising edge.
   typedef struct {
      longint           hi;
      longint           pos;
      logic             vm;
      logic [VLMAX-1:0] mask;
      longint           off0;
      longint           off1;
      logic [1:0]       wen;
      logic             busy;
      logic             done;
      logic             ready;
   } mdl_t;

   mdl_t m;

   function automatic logic m_lane_on(mdl_t s, longint e);
      if (s.vm) return 1'b1;
      if (e < 0 || e >= VLMAX) return 1'b0;
      return s.mask[int'(e)];
   endfunction

   // Present the pair starting at element p, or finish if p is past the end.
   function automatic mdl_t m_present(mdl_t s, longint p);
      mdl_t r = s;
      r.busy  = 1'b1;
      r.ready = 1'b0;
      if (p < s.hi) begin
         r.pos    = p;
         r.off0   = p;
         r.off1   = p + 1;
         r.wen[0] = m_lane_on(s, p);
         r.wen[1] = (p + 1 < s.hi) && m_lane_on(s, p + 1);
         r.done   = 1'b0;
      end else begin
         r.wen  = 2'b00;
         r.done = 1'b1;
      end
      return r;
   endfunction

   function automatic mdl_t m_next(mdl_t s, logic rst_i, logic flush_i, logic start_i,
                                   logic stall_i, longint vl_i, longint vs_i,
                                   logic vm_i, logic [VLMAX-1:0] mask_i);
      mdl_t r = s;
      if (rst_i) begin
         r.hi = 0; r.pos = 0; r.vm = 1'b1; r.mask = '0;
         r.off0 = 0; r.off1 = 0; r.wen = 2'b00;
         r.busy = 1'b0; r.done = 1'b0; r.ready = 1'b1;
      end else if (flush_i) begin
         r.wen = 2'b00; r.busy = 1'b0; r.done = 1'b0; r.ready = 1'b1;
      end else if (s.done) begin
         r.done = 1'b0; r.busy = 1'b0; r.ready = 1'b1; r.wen = 2'b00;
      end else if (!s.busy) begin
         if (start_i) begin
            r.hi   = (vl_i > VLMAX) ? VLMAX : vl_i;
            r.vm   = vm_i;
            r.mask = mask_i;
            r      = m_present(r, vs_i);
         end
      end else if (!stall_i) begin
         r = m_present(s, s.pos + 2);
      end
      return r;
   endfunction

   // Advance the model on every rising edge using the inputs the DUT sees.
   always @(posedge CLK) begin
`ifdef RV32V_SEQ_MASK_EN
      m <= m_next(m, RST, flush, start, stall, longint'(vl), longint'(vstart), vm, mask_v0);
`else
      m <= m_next(m, RST, flush, start, stall, longint'(vl), longint'(vstart), 1'b1, '0);
`endif
   end

   // Compare every output against the model on each falling edge.
   always @(negedge CLK) begin
      if (check_en) begin
         vectors++;
         if (woffset0 !== offset_t'(m.off0) || woffset1 !== offset_t'(m.off1) ||
             wen !== m.wen || busy !== m.busy || done !== m.done || ready !== m.ready) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t got off=(%0d,%0d) wen=%b busy=%b done=%b ready=%b want off=(%0d,%0d) wen=%b busy=%b done=%b ready=%b",
                     $time, woffset0, woffset1, wen, busy, done, ready,
                     m.off0, m.off1, m.wen, m.busy, m.done, m.ready);
         end
      end
   end

   task automatic lit(input string nm, input longint got, input longint want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic lane(input string nm, input longint o0, input longint o1, input longint w);
      lit({nm, "_off0"}, longint'(woffset0), o0);
      lit({nm, "_off1"}, longint'(woffset1), o1);
      lit({nm, "_wen"}, longint'(wen), w);
   endtask

   task automatic cyc();
      @(negedge CLK);
   endtask

   // Wait (bounded) for ready, then hold start for one cycle.
   task automatic issue(input logic [31:0] v, input logic [31:0] s);
      int n = 0;
      while (!ready && n < 40) begin
         @(negedge CLK);
         n++;
      end
      lit("ready_before_start", longint'(ready), 1);
      start  = 1'b1;
      vl     = v;
      vstart = s;
      @(negedge CLK);
      start  = 1'b0;
   endtask

   initial begin
      RST = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; vl = 32'd0; vstart = 32'd0;
`ifdef RV32V_SEQ_MASK_EN
      vm = 1'b1; mask_v0 = '0;
`endif
      @(negedge CLK);
      check_en = 1'b1;
      @(negedge CLK);
      lit("rst_ready", longint'(ready), 1);
      lit("rst_busy", longint'(busy), 0);
      lit("rst_done", longint'(done), 0);
      lane("rst", 0, 0, 0);
      RST = 1'b0;
      cyc();

      // vl=8: four full pairs, then a one-cycle done
      issue(32'd8, 32'd0);
      for (int k = 0; k < 4; k++) begin
         lane("vl8", 2 * k, 2 * k + 1, 3);
         lit("vl8_nodone", longint'(done), 0);
         cyc();
      end
      lit("vl8_done", longint'(done), 1);
      lit("vl8_done_wen", longint'(wen), 0);
      cyc();
      lit("vl8_done_once", longint'(done), 0);
      lit("vl8_ready", longint'(ready), 1);

      // vl=5: odd tail presents wen=01
      issue(32'd5, 32'd0);
      lane("vl5_c1", 0, 1, 3); cyc();
      lane("vl5_c2", 2, 3, 3); cyc();
      lane("vl5_c3", 4, 5, 1); cyc();
      lit("vl5_done", longint'(done), 1);
      cyc();

      // vstart == vl and vl == 0: straight to done, nothing issued
      issue(32'd4, 32'd4);
      lit("vs4_wen", longint'(wen), 0);
      lit("vs4_done", longint'(done), 1);
      lit("vs4_busy", longint'(busy), 1);
      cyc();
      lit("vs4_done_once", longint'(done), 0);
      issue(32'd0, 32'd0);
      lit("vl0_wen", longint'(wen), 0);
      lit("vl0_done", longint'(done), 1);
      cyc();
      lit("vl0_ready", longint'(ready), 1);

      // vl=6 with stall held for three cycles on the second pair
      issue(32'd6, 32'd0);
      lane("st_c1", 0, 1, 3); cyc();
      lane("st_c2", 2, 3, 3); stall = 1'b1; cyc();
      lane("st_c3", 2, 3, 3); cyc();
      lane("st_c4", 2, 3, 3); cyc();
      lane("st_c5", 2, 3, 3); stall = 1'b0; cyc();
      lane("st_c6", 4, 5, 3);
      lit("st_c6_nodone", longint'(done), 0); cyc();
      lit("st_c7_done", longint'(done), 1);
      cyc();

      // flush on the second RUN cycle of vl=16, then a normal instruction
      issue(32'd16, 32'd0);
      lane("fl_c1", 0, 1, 3); cyc();
      lane("fl_c2", 2, 3, 3); flush = 1'b1; cyc();
      flush = 1'b0;
      lit("fl_wen", longint'(wen), 0);
      lit("fl_busy", longint'(busy), 0);
      lit("fl_ready", longint'(ready), 1);
      for (int k = 0; k < 3; k++) begin
         lit("fl_nodone", longint'(done), 0);
         cyc();
      end
      issue(32'd3, 32'd1);
      lane("fl_after", 1, 2, 3); cyc();
      lit("fl_after_done", longint'(done), 1);
      cyc();

      // vl above VLMAX clamps; a start during RUN is ignored
      issue(32'd200, 32'd125);
      lane("clamp_c1", 125, 126, 3);
      start = 1'b1; vl = 32'd2; vstart = 32'd0;
      cyc();
      start = 1'b0;
      lane("clamp_c2", 127, 128, 1); cyc();
      lit("clamp_done", longint'(done), 1);
      cyc();

      // reset mid-RUN discards the instruction
      issue(32'd10, 32'd0);
      cyc();
      RST = 1'b1; cyc();
      RST = 1'b0;
      lane("rstrun", 0, 0, 0);
      lit("rstrun_ready", longint'(ready), 1);
      for (int k = 0; k < 6; k++) begin
         lit("rstrun_nodone", longint'(done), 0);
         cyc();
      end

      // flush wins over start in IDLE
      flush = 1'b1; start = 1'b1; vl = 32'd4; vstart = 32'd0;
      cyc();
      flush = 1'b0; start = 1'b0;
      lit("flstart_busy", longint'(busy), 0);
      lit("flstart_ready", longint'(ready), 1);
      cyc();

`ifdef RV32V_SEQ_MASK_EN
      vm = 1'b0; mask_v0 = '0; mask_v0[3:0] = 4'b1010;
      issue(32'd4, 32'd0);
      lit("mask_c1_wen", longint'(wen), 2); cyc();
      lit("mask_c2_wen", longint'(wen), 2); cyc();
      lit("mask_done", longint'(done), 1); cyc();
      vm = 1'b1;
      issue(32'd4, 32'd0);
      lit("nomask_c1_wen", longint'(wen), 3); cyc();
      lit("nomask_c2_wen", longint'(wen), 3); cyc();
      cyc();
`endif

      repeat (3) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
